pwm_die_monitor: RTL and testbench
==================================

// Module: pwm_die_monitor
// PURPOSE
//   Receive-side checker for the complementary dead-time PWM pair (a/b) driven by half_pwm_die.
//   Samples both pulse lines, measures the A high width, the A->B dead time, the B high width
//   and the B->A dead time in io_clk cycles, then compares them against expected values.
//   Flags shoot-through (A and B high together), edge-sequence errors and loss of pulses.
//   Sits on the loopback/board-test path beside the pulse generator; results go to LEDs or a debug bus.
// PARAMETERS
//   _RAM_WIDTH   32      width of the measurement counters and the expected-value inputs
//   TIMEOUT      1000    cycles without an edge before err_timeout is raised (active states only)
//   SYNC_STAGES  2       input synchroniser depth, minimum 2
// PORTS
//   io_clk            in   1    single clock; every register in the block is on its rising edge
//   io_rst            in   1    synchronous, active-high reset
//   io_en             in   1    monitor enable; low forces IDLE
//   io_pulseIn_a      in   1    pulse line A (may be asynchronous)
//   io_pulseIn_b      in   1    pulse line B (may be asynchronous)
//   exp_pulse_period  in   W    expected high width of A and of B, in cycles
//   exp_die_period    in   W    expected dead time in each direction, in cycles
//   err_clr           in   1    one-cycle pulse that clears the sticky error flags
//   meas_pulse_a      out  W    last measured A high width
//   meas_pulse_b      out  W    last measured B high width
//   meas_die_ab       out  W    last dead time, A falling edge to B rising edge
//   meas_die_ba       out  W    last dead time, B falling edge to A rising edge
//   meas_valid        out  1    one-cycle strobe: all four meas_* hold a new complete cycle
//   meas_cnt          out  16   count of complete cycles measured; wraps from 0xFFFF to 0
//   mismatch          out  1    meas_* differ from the expected values; updated with meas_valid
//   err_overlap       out  1    sticky: A and B high together
//   err_seq           out  1    sticky: an edge arrived out of order
//   err_timeout       out  1    sticky: no edge for TIMEOUT cycles in an active state
//   busy              out  1    state != IDLE
// BEHAVIOUR
//   - Reset: every output is 0, state is IDLE, and the counters and synchroniser stages are 0.
//   - Input path: a_s/b_s are the outputs of the SYNC_STAGES flops; a_d/b_d are a_s/b_s delayed one more cycle.
//     rise = s & ~d, fall = ~s & d. An input edge is detected SYNC_STAGES+1 cycles after it happens.
//   - States: IDLE -> A_HIGH -> DEAD_AB -> B_HIGH -> DEAD_BA -> A_HIGH ...
//     IDLE:    rise_a with b_s=0 -> A_HIGH, cnt<=1.
//     A_HIGH:  fall_a -> latch pa=cnt, go to DEAD_AB, cnt<=1.
//     DEAD_AB: rise_b -> latch dab=cnt, go to B_HIGH, cnt<=1.
//     B_HIGH:  fall_b -> latch pb=cnt, go to DEAD_BA, cnt<=1.
//     DEAD_BA: rise_a -> latch dba=cnt, go to A_HIGH, cnt<=1, and publish the cycle.
//     In every state, a cycle with no expected edge does cnt<=cnt+1. cnt saturates at all-ones.
//     Width rule: an N-cycle high level on a_s measures N. An N-cycle gap measures N.
//   - Publish: on the cycle after the DEAD_BA->A_HIGH edge:
//     meas_pulse_a=pa, meas_die_ab=dab, meas_pulse_b=pb, meas_die_ba=dba, meas_valid=1, meas_cnt+1.
//     mismatch = (pa!=exp_pulse_period)|(pb!=exp_pulse_period)|(dab!=exp_die_period)|(dba!=exp_die_period).
//     mismatch is registered on that same cycle and held until the next publish.
//     The first A cycle after IDLE is measured, but a cycle is published only after a full A..DEAD_BA pass.
//   - a_s & b_s in any state, including IDLE -> err_overlap<=1, go to IDLE, no publish.
//   - Wrong-line edge for the current state (rise_b in A_HIGH excluded, see overlap; rise_a in DEAD_AB;
//     rise_b in DEAD_BA) -> err_seq<=1, go to IDLE.
//   - Timeout: cnt reaches TIMEOUT in any non-IDLE state -> err_timeout<=1, go to IDLE.
//   - err_clr clears all three sticky flags. A new error on the same cycle wins, so the flag stays 1.
//   - io_en=0: state goes to IDLE and cnt goes to 0; meas_*, meas_cnt and the error flags hold their values.
//     When io_en returns to 1, the block waits in IDLE for a clean rise_a.
//   - io_rst mid-cycle: everything returns to reset values on the next edge; the partial cycle is discarded.
// TESTING
//   1. A high 10, gap 3, B high 10, gap 3, repeated 3 times; exp=10/3
//      -> 2 meas_valid strobes, meas_*=10/3/10/3, mismatch=0, meas_cnt=2.
//   2. Same stimulus with exp_die_period=4 -> meas_valid with mismatch=1 and meas_die_ab=3; no sticky flags set.
//   3. B rises 1 cycle before A falls -> err_overlap=1, busy=0; the next cycle is remeasured cleanly;
//      err_clr clears the flag.
//   4. A pulses twice with B held low -> err_seq=1 on the second rise_a, busy=0, no meas_valid.
//   5. Hold A high for TIMEOUT+5 cycles -> err_timeout=1 after TIMEOUT cycles, busy=0.
//   6. Assert io_rst in B_HIGH, then resume legal pulses -> outputs 0 during reset,
//      and the first meas_valid arrives only after a full new A..DEAD_BA cycle.

Source files
------------

// File: rtl/pwm_die_monitor.sv
// pwm_die_monitor: measures complementary A/B pulse widths and dead times and flags sequence faults
module pwm_die_monitor #(
   parameter int _RAM_WIDTH  = 32,
   parameter int TIMEOUT     = 1000,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  io_clk,
   input  logic                  io_rst,
   input  logic                  io_en,
   input  logic                  io_pulseIn_a,
   input  logic                  io_pulseIn_b,
   input  logic [_RAM_WIDTH-1:0] exp_pulse_period,
   input  logic [_RAM_WIDTH-1:0] exp_die_period,
   input  logic                  err_clr,
   output logic [_RAM_WIDTH-1:0] meas_pulse_a,
   output logic [_RAM_WIDTH-1:0] meas_pulse_b,
   output logic [_RAM_WIDTH-1:0] meas_die_ab,
   output logic [_RAM_WIDTH-1:0] meas_die_ba,
   output logic                  meas_valid,
   output logic [15:0]           meas_cnt,
   output logic                  mismatch,
   output logic                  err_overlap,
   output logic                  err_seq,
   output logic                  err_timeout,
   output logic                  busy
);
   localparam int W = _RAM_WIDTH;
   localparam logic [W-1:0] CNT_ONE = W'(1);
   localparam logic [W-1:0] CNT_TO  = W'(TIMEOUT);

   typedef enum logic [2:0] {IDLE, A_HIGH, DEAD_AB, B_HIGH, DEAD_BA} state_t;

   state_t state_q, state_d;
   logic [SYNC_STAGES-1:0] a_sync_q, a_sync_d, b_sync_q, b_sync_d;
   logic a_dly_q, b_dly_q;
   logic [W-1:0] cnt_q, cnt_d, pa_q, pa_d, dab_q, dab_d, pb_q, pb_d;
   logic [W-1:0] meas_pulse_a_q, meas_pulse_a_d, meas_pulse_b_q, meas_pulse_b_d;
   logic [W-1:0] meas_die_ab_q, meas_die_ab_d, meas_die_ba_q, meas_die_ba_d;
   logic meas_valid_q, meas_valid_d, mismatch_q, mismatch_d;
   logic [15:0] meas_cnt_q, meas_cnt_d;
   logic err_overlap_q, err_overlap_d, err_seq_q, err_seq_d, err_timeout_q, err_timeout_d;
   logic a_s, b_s, rise_a, fall_a, rise_b, fall_b;
   logic ov, sq, timeout_hit, publish;

   assign a_s    = a_sync_q[SYNC_STAGES-1];
   assign b_s    = b_sync_q[SYNC_STAGES-1];
   assign rise_a = a_s & ~a_dly_q;
   assign fall_a = ~a_s & a_dly_q;
   assign rise_b = b_s & ~b_dly_q;
   assign fall_b = ~b_s & b_dly_q;
   assign a_sync_d = {a_sync_q[SYNC_STAGES-2:0], io_pulseIn_a};
   assign b_sync_d = {b_sync_q[SYNC_STAGES-2:0], io_pulseIn_b};

   // All state, counters and synchroniser stages clear on the synchronous reset
   always_ff @(posedge io_clk) begin
      if (io_rst) begin
         state_q        <= IDLE;
         a_sync_q       <= '0;
         b_sync_q       <= '0;
         a_dly_q        <= 1'b0;
         b_dly_q        <= 1'b0;
         cnt_q          <= '0;
         pa_q           <= '0;
         dab_q          <= '0;
         pb_q           <= '0;
         meas_pulse_a_q <= '0;
         meas_pulse_b_q <= '0;
         meas_die_ab_q  <= '0;
         meas_die_ba_q  <= '0;
         meas_valid_q   <= 1'b0;
         meas_cnt_q     <= '0;
         mismatch_q     <= 1'b0;
         err_overlap_q  <= 1'b0;
         err_seq_q      <= 1'b0;
         err_timeout_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         a_sync_q       <= a_sync_d;
         b_sync_q       <= b_sync_d;
         a_dly_q        <= a_s;
         b_dly_q        <= b_s;
         cnt_q          <= cnt_d;
         pa_q           <= pa_d;
         dab_q          <= dab_d;
         pb_q           <= pb_d;
         meas_pulse_a_q <= meas_pulse_a_d;
         meas_pulse_b_q <= meas_pulse_b_d;
         meas_die_ab_q  <= meas_die_ab_d;
         meas_die_ba_q  <= meas_die_ba_d;
         meas_valid_q   <= meas_valid_d;
         meas_cnt_q     <= meas_cnt_d;
         mismatch_q     <= mismatch_d;
         err_overlap_q  <= err_overlap_d;
         err_seq_q      <= err_seq_d;
         err_timeout_q  <= err_timeout_d;
      end
   end

   // Edge sequencer: advances on the expected edge, latches the finished segment length, traps faults
   always_comb begin
      state_d     = state_q;
      cnt_d       = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
      pa_d        = pa_q;
      dab_d       = dab_q;
      pb_d        = pb_q;
      ov          = 1'b0;
      sq          = 1'b0;
      timeout_hit = 1'b0;
      publish     = 1'b0;
      if (!io_en) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (a_s && b_s) begin
         ov      = 1'b1;
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE:    if (rise_a) begin
                        state_d = A_HIGH;
                        cnt_d   = CNT_ONE;
                     end
            A_HIGH:  if (fall_a) begin
                        pa_d    = cnt_q;
                        state_d = DEAD_AB;
                        cnt_d   = CNT_ONE;
                     end
            DEAD_AB: if (rise_b) begin
                        dab_d   = cnt_q;
                        state_d = B_HIGH;
                        cnt_d   = CNT_ONE;
                     end else if (rise_a) sq = 1'b1;
            B_HIGH:  if (fall_b) begin
                        pb_d    = cnt_q;
                        state_d = DEAD_BA;
                        cnt_d   = CNT_ONE;
                     end
            DEAD_BA: if (rise_a) begin
                        publish = 1'b1;
                        state_d = A_HIGH;
                        cnt_d   = CNT_ONE;
                     end else if (rise_b) sq = 1'b1;
            default: state_d = IDLE;
         endcase
         if (sq) begin
            state_d = IDLE;
            cnt_d   = '0;
         end else if (state_q != IDLE && state_d == state_q && cnt_q >= CNT_TO) begin
            timeout_hit = 1'b1;
            state_d     = IDLE;
            cnt_d       = '0;
         end
      end
   end

   // Result registers: publish a completed cycle, keep sticky flags until cleared
   always_comb begin
      meas_valid_d   = publish;
      meas_pulse_a_d = publish ? pa_q : meas_pulse_a_q;
      meas_die_ab_d  = publish ? dab_q : meas_die_ab_q;
      meas_pulse_b_d = publish ? pb_q : meas_pulse_b_q;
      meas_die_ba_d  = publish ? cnt_q : meas_die_ba_q;
      meas_cnt_d     = meas_cnt_q + {15'd0, publish};
      mismatch_d     = publish ? ((pa_q != exp_pulse_period) | (pb_q != exp_pulse_period) |
                                  (dab_q != exp_die_period) | (cnt_q != exp_die_period)) : mismatch_q;
      err_overlap_d  = (err_overlap_q & ~err_clr) | ov;
      err_seq_d      = (err_seq_q & ~err_clr) | sq;
      err_timeout_d  = (err_timeout_q & ~err_clr) | timeout_hit;
   end

   // Status outputs
   always_comb begin
      busy         = state_q != IDLE;
      meas_pulse_a = meas_pulse_a_q;
      meas_pulse_b = meas_pulse_b_q;
      meas_die_ab  = meas_die_ab_q;
      meas_die_ba  = meas_die_ba_q;
      meas_valid   = meas_valid_q;
      meas_cnt     = meas_cnt_q;
      mismatch     = mismatch_q;
      err_overlap  = err_overlap_q;
      err_seq      = err_seq_q;
      err_timeout  = err_timeout_q;
   end
endmodule

// File: tb/tb_pwm_die_monitor.sv
// tb_pwm_die_monitor: randomized scenarios checked against a segment-level model of the A/B pulse train
module tb_pwm_die_monitor;
   localparam int W  = 32;
   localparam int TO = 100;

   logic clk, io_rst, io_en, a_in, b_in, err_clr;
   logic [W-1:0] exp_pw, exp_dw;
   logic [W-1:0] meas_pulse_a, meas_pulse_b, meas_die_ab, meas_die_ba;
   logic meas_valid, mismatch, err_overlap, err_seq, err_timeout, busy;
   logic [15:0] meas_cnt;

   int errors = 0;
   int checks = 0;
   logic [4*W-1:0] obs_q[$], exp_q[$];
   logic mm_q[$], exp_mm_q[$];
   logic [15:0] exp_cnt;

   pwm_die_monitor #(._RAM_WIDTH(W), .TIMEOUT(TO), .SYNC_STAGES(2)) dut (
      .io_clk(clk), .io_rst(io_rst), .io_en(io_en),
      .io_pulseIn_a(a_in), .io_pulseIn_b(b_in),
      .exp_pulse_period(exp_pw), .exp_die_period(exp_dw), .err_clr(err_clr),
      .meas_pulse_a(meas_pulse_a), .meas_pulse_b(meas_pulse_b),
      .meas_die_ab(meas_die_ab), .meas_die_ba(meas_die_ba),
      .meas_valid(meas_valid), .meas_cnt(meas_cnt), .mismatch(mismatch),
      .err_overlap(err_overlap), .err_seq(err_seq), .err_timeout(err_timeout), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input logic a, input logic b);
      a_in = a;
      b_in = b;
      @(posedge clk);
      #1;
      if (meas_valid === 1'b1) begin
         obs_q.push_back({meas_pulse_a, meas_die_ab, meas_pulse_b, meas_die_ba});
         mm_q.push_back(mismatch);
      end
   endtask

   task automatic hold(input logic a, input logic b, input int n);
      repeat (n) step(a, b);
   endtask

   task automatic clear_queues();
      obs_q.delete();
      exp_q.delete();
      mm_q.delete();
      exp_mm_q.delete();
   endtask

   task automatic rest();
      io_en = 1'b0;
      hold(0, 0, 4);
      err_clr = 1'b1;
      step(0, 0);
      err_clr = 1'b0;
      io_en = 1'b1;
      hold(0, 0, 3);
   endtask

   // Drives n legal A/B cycles; cycle k is expected to publish when A rises for cycle k+1
   task automatic play(input int n, input bit rnd, input int pw, input int dw);
      int w[4];
      for (int i = 0; i < n; i++) begin
         for (int j = 0; j < 4; j++) w[j] = rnd ? int'($urandom_range(1, 15)) : ((j % 2 == 0) ? pw : dw);
         hold(1, 0, w[0]);
         hold(0, 0, w[1]);
         hold(0, 1, w[2]);
         hold(0, 0, w[3]);
         if (i < n - 1) begin
            exp_q.push_back({W'(w[0]), W'(w[1]), W'(w[2]), W'(w[3])});
            exp_mm_q.push_back((w[0] != int'(exp_pw)) || (w[2] != int'(exp_pw)) ||
                               (w[1] != int'(exp_dw)) || (w[3] != int'(exp_dw)));
            exp_cnt = exp_cnt + 16'd1;
         end
      end
   endtask

   task automatic test_reset();
      io_rst = 1'b1;
      io_en = 1'b0;
      err_clr = 1'b0;
      exp_pw = '0;
      exp_dw = '0;
      hold(0, 0, 3);
      checks++; if (meas_pulse_a !== '0) begin errors++; $display("FAIL reset_pulse_a got %h want 0", meas_pulse_a); end
      checks++; if (meas_pulse_b !== '0) begin errors++; $display("FAIL reset_pulse_b got %h want 0", meas_pulse_b); end
      checks++; if (meas_die_ab !== '0) begin errors++; $display("FAIL reset_die_ab got %h want 0", meas_die_ab); end
      checks++; if (meas_die_ba !== '0) begin errors++; $display("FAIL reset_die_ba got %h want 0", meas_die_ba); end
      checks++; if (meas_cnt !== 16'd0) begin errors++; $display("FAIL reset_meas_cnt got %h want 0", meas_cnt); end
      checks++; if ({meas_valid, mismatch, err_overlap, err_seq, err_timeout, busy} !== 6'b0)
         begin errors++; $display("FAIL reset_flags got %b want 000000", {meas_valid, mismatch, err_overlap, err_seq, err_timeout, busy}); end
      io_rst = 1'b0;
      exp_cnt = 16'd0;
      io_en = 1'b1;
      hold(0, 0, 3);
   endtask

   task automatic test_nominal();
      clear_queues();
      exp_pw = 32'd10;
      exp_dw = 32'd3;
      play(3, 0, 10, 3);
      checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL nominal_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL nominal_meas[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
         checks++; if (mm_q[i] !== exp_mm_q[i]) begin errors++; $display("FAIL nominal_mismatch[%0d] got %b want %b", i, mm_q[i], exp_mm_q[i]); end
      end
      checks++; if (meas_cnt !== exp_cnt) begin errors++; $display("FAIL nominal_meas_cnt got %0d want %0d", meas_cnt, exp_cnt); end
      rest();
   endtask

   task automatic test_mismatch();
      clear_queues();
      exp_pw = 32'd10;
      exp_dw = 32'd4;
      play(3, 0, 10, 3);
      checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL mism_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL mism_meas[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
         checks++; if (mm_q[i] !== exp_mm_q[i]) begin errors++; $display("FAIL mism_flag[%0d] got %b want %b", i, mm_q[i], exp_mm_q[i]); end
      end
      checks++; if (meas_die_ab !== 32'd3) begin errors++; $display("FAIL mism_die_ab got %0d want 3", meas_die_ab); end
      checks++; if ({err_overlap, err_seq, err_timeout} !== 3'b0) begin errors++; $display("FAIL mism_sticky got %b want 000", {err_overlap, err_seq, err_timeout}); end
      checks++; if (meas_cnt !== exp_cnt) begin errors++; $display("FAIL mism_meas_cnt got %0d want %0d", meas_cnt, exp_cnt); end
      rest();
   endtask

   task automatic test_overlap();
      clear_queues();
      exp_pw = 32'd10;
      exp_dw = 32'd3;
      hold(1, 0, 9);
      hold(1, 1, 1);
      hold(0, 1, 9);
      hold(0, 0, 3);
      checks++; if (err_overlap !== 1'b1) begin errors++; $display("FAIL overlap_flag got %b want 1", err_overlap); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL overlap_busy got %b want 0", busy); end
      checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL overlap_no_valid got %0d want 0", obs_q.size()); end
      play(3, 0, 10, 3);
      checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL overlap_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL overlap_meas[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
         checks++; if (mm_q[i] !== exp_mm_q[i]) begin errors++; $display("FAIL overlap_mismatch[%0d] got %b want %b", i, mm_q[i], exp_mm_q[i]); end
      end
      err_clr = 1'b1;
      step(0, 0);
      err_clr = 1'b0;
      step(0, 0);
      checks++; if (err_overlap !== 1'b0) begin errors++; $display("FAIL overlap_clear got %b want 0", err_overlap); end
      rest();
   endtask

   task automatic test_seq();
      clear_queues();
      hold(1, 0, 5);
      hold(0, 0, 3);
      hold(1, 0, 5);
      hold(0, 0, 2);
      checks++; if (err_seq !== 1'b1) begin errors++; $display("FAIL seq_flag got %b want 1", err_seq); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL seq_busy got %b want 0", busy); end
      checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL seq_no_valid got %0d want 0", obs_q.size()); end
      rest();
      checks++; if (err_seq !== 1'b0) begin errors++; $display("FAIL seq_clear got %b want 0", err_seq); end
   endtask

   task automatic test_timeout();
      clear_queues();
      hold(1, 0, TO - 5);
      checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL timeout_early got %b want 0", err_timeout); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_busy_early got %b want 1", busy); end
      hold(1, 0, 10);
      checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag got %b want 1", err_timeout); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got %b want 0", busy); end
      hold(0, 0, 2);
      rest();
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         bit rnd;
         int pw, dw, n;
         clear_queues();
         rnd = bit'($urandom_range(0, 1));
         pw = int'($urandom_range(1, 15));
         dw = int'($urandom_range(1, 15));
         n = int'($urandom_range(2, 5));
         exp_pw = rnd ? W'($urandom_range(1, 15)) : W'(pw);
         exp_dw = rnd ? W'($urandom_range(1, 15)) : W'(dw);
         play(n, rnd, pw, dw);
         checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand%0d_count got %0d want %0d", r, obs_q.size(), exp_q.size()); end
         for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_meas[%0d] got %h want %h", r, i, obs_q[i], exp_q[i]); end
            checks++; if (mm_q[i] !== exp_mm_q[i]) begin errors++; $display("FAIL rand%0d_mismatch[%0d] got %b want %b", r, i, mm_q[i], exp_mm_q[i]); end
         end
         checks++; if (meas_cnt !== exp_cnt) begin errors++; $display("FAIL rand%0d_meas_cnt got %0d want %0d", r, meas_cnt, exp_cnt); end
         rest();
      end
   endtask

   task automatic test_reset_mid();
      clear_queues();
      exp_pw = 32'd10;
      exp_dw = 32'd3;
      hold(1, 0, 10);
      hold(0, 0, 3);
      hold(0, 1, 5);
      io_rst = 1'b1;
      hold(0, 1, 2);
      exp_cnt = 16'd0;
      checks++; if (meas_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_meas_cnt got %0d want 0", meas_cnt); end
      checks++; if ({meas_pulse_a, meas_die_ba} !== '0) begin errors++; $display("FAIL rstmid_meas got %h want 0", {meas_pulse_a, meas_die_ba}); end
      checks++; if ({meas_valid, mismatch, err_overlap, err_seq, err_timeout, busy} !== 6'b0)
         begin errors++; $display("FAIL rstmid_flags got %b want 000000", {meas_valid, mismatch, err_overlap, err_seq, err_timeout, busy}); end
      io_rst = 1'b0;
      hold(0, 1, 3);
      hold(0, 0, 3);
      play(3, 0, 10, 3);
      checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL rstmid_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_meas[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
      end
      checks++; if (meas_cnt !== exp_cnt) begin errors++; $display("FAIL rstmid_final_cnt got %0d want %0d", meas_cnt, exp_cnt); end
      rest();
   endtask

   initial begin
      a_in = 1'b0;
      b_in = 1'b0;
      exp_cnt = 16'd0;
      test_reset();
      test_nominal();
      test_mismatch();
      test_overlap();
      test_seq();
      test_timeout();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
